dmem_arbiter: RTL and testbench

- Sits between the pipeline MEM stage, the debug unit and the byte-addressable data memory (word/half/byte access, alignment-checked).
- In normal operation the CPU owns the memory through a combinational passthrough.
- On a debug dump request, issued while the CPU is halted, an FSM takes the memory and streams every word to the debug unit over a valid/ready handshake.
- Dump words go out in ascending address order; the FSM then returns ownership to the CPU.

---
 rtl/dmem_arbiter_if.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug unit, the data memory and
// dmem_arbiter. The slave view is the arbiter's; the master view is the
// surrounding environment's.
interface dmem_arbiter_if #(
   parameter int NB_DATA_BUS = 32,
   parameter int NB_ADDRESS  = 6
);
   // CPU side
   logic                   i_cpu_r_en;
   logic [NB_ADDRESS-1:0]  i_cpu_r_addr;
   logic                   i_cpu_r_signing;
   logic [1:0]             i_cpu_r_addressing;
   logic                   i_cpu_w_en;
   logic [NB_ADDRESS-1:0]  i_cpu_w_addr;
   logic [NB_DATA_BUS-1:0] i_cpu_w_data;
   logic [1:0]             i_cpu_w_addressing;
   logic [NB_DATA_BUS-1:0] o_cpu_r_data;
   logic                   o_cpu_stall;

   // Debug side
   logic                   i_dbg_halted;
   logic                   i_dbg_dump_start;
   logic                   i_dbg_ready;
   logic                   o_dbg_valid;
   logic [NB_DATA_BUS-1:0] o_dbg_data;
   logic [NB_ADDRESS-1:0]  o_dbg_addr;
   logic                   o_dbg_done;

   // Memory side
   logic                   o_mem_r_en;
   logic [NB_ADDRESS-1:0]  o_mem_r_addr;
   logic                   o_mem_r_signing;
   logic [1:0]             o_mem_r_addressing;
   logic                   o_mem_w_en;
   logic [NB_ADDRESS-1:0]  o_mem_w_addr;
   logic [NB_DATA_BUS-1:0] o_mem_w_data;
   logic [1:0]             o_mem_w_addressing;
   logic [NB_DATA_BUS-1:0] i_mem_r_data;

   modport slave (
      input  i_cpu_r_en, i_cpu_r_addr, i_cpu_r_signing, i_cpu_r_addressing,
      input  i_cpu_w_en, i_cpu_w_addr, i_cpu_w_data, i_cpu_w_addressing,
      output o_cpu_r_data, o_cpu_stall,
      input  i_dbg_halted, i_dbg_dump_start, i_dbg_ready,
      output o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done,
      output o_mem_r_en, o_mem_r_addr, o_mem_r_signing, o_mem_r_addressing,
      output o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
      input  i_mem_r_data
   );

   modport master (
      output i_cpu_r_en, i_cpu_r_addr, i_cpu_r_signing, i_cpu_r_addressing,
      output i_cpu_w_en, i_cpu_w_addr, i_cpu_w_data, i_cpu_w_addressing,
      input  o_cpu_r_data, o_cpu_stall,
      output i_dbg_halted, i_dbg_dump_start, i_dbg_ready,
      input  o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done,
      input  o_mem_r_en, o_mem_r_addr, o_mem_r_signing, o_mem_r_addressing,
      input  o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
      output i_mem_r_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU owns memory through a combinational
// passthrough; a debug dump request (while halted) hands memory to an FSM
// that streams every word, in ascending order, over valid/ready.
module dmem_arbiter #(
   parameter int NB_DATA_BUS = 32,
   parameter int N_ADDRESS   = 64,
   parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
   input  logic         i_clk,
   input  logic         i_reset,
   dmem_arbiter_if.slave bus
);
   localparam int N_WORDS = N_ADDRESS / 4;
   localparam int NB_CNT  = NB_ADDRESS - 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [NB_CNT-1:0]      r_cnt;
   logic [NB_CNT-1:0]      w_cnt_next;
   logic                   r_pending;
   logic                   w_pending_next;
   logic                   r_dbg_valid;
   logic                   w_dbg_valid_next;
   logic [NB_DATA_BUS-1:0] r_dbg_data;
   logic [NB_DATA_BUS-1:0] w_dbg_data_next;
   logic [NB_ADDRESS-1:0]  r_dbg_addr;
   logic [NB_ADDRESS-1:0]  w_dbg_addr_next;

   logic                   w_req;
   logic                   w_handshake;
   logic                   w_last;
   logic [NB_ADDRESS-1:0]  w_word_addr;

   assign w_req       = r_pending | bus.i_dbg_dump_start;
   assign w_handshake = r_dbg_valid & bus.i_dbg_ready;
   assign w_last      = (r_cnt == NB_CNT'(N_WORDS - 1));
   assign w_word_addr = {r_cnt, 2'b00};

   // State and dump datapath registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_pending   <= 1'b0;
         r_dbg_valid <= 1'b0;
         r_dbg_data  <= '0;
         r_dbg_addr  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_pending   <= w_pending_next;
         r_dbg_valid <= w_dbg_valid_next;
         r_dbg_data  <= w_dbg_data_next;
         r_dbg_addr  <= w_dbg_addr_next;
      end
   end

   // Next-state logic: request latching, word fetch and handshake sequencing
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_pending_next   = 1'b0;
      w_dbg_valid_next = r_dbg_valid;
      w_dbg_data_next  = r_dbg_data;
      w_dbg_addr_next  = r_dbg_addr;
      case (r_state)
         ST_IDLE: begin
            // a request waits here until the CPU is halted
            w_pending_next = w_req;
            if (w_req && bus.i_dbg_halted) begin
               w_state_next   = ST_RD;
               w_pending_next = 1'b0;
            end
         end
         ST_RD: w_state_next = ST_WAIT;
         ST_WAIT: begin
            w_dbg_data_next  = bus.i_mem_r_data;
            w_dbg_addr_next  = w_word_addr;
            w_dbg_valid_next = 1'b1;
            w_state_next     = ST_SEND;
         end
         ST_SEND: begin
            if (w_handshake) begin
               w_dbg_valid_next = 1'b0;
               if (w_last) begin
                  w_cnt_next   = '0;
                  w_state_next = ST_DONE;
               end else begin
                  w_cnt_next   = r_cnt + 1'b1;
                  w_state_next = ST_RD;
               end
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Memory port mux: CPU passthrough in IDLE, dump read in RD, quiet otherwise
   always_comb begin
      bus.o_mem_r_en         = 1'b0;
      bus.o_mem_r_addr       = '0;
      bus.o_mem_r_signing    = 1'b0;
      bus.o_mem_r_addressing = 2'b00;
      bus.o_mem_w_en         = 1'b0;
      bus.o_mem_w_addr       = '0;
      bus.o_mem_w_data       = '0;
      bus.o_mem_w_addressing = 2'b00;
      if (r_state == ST_IDLE) begin
         bus.o_mem_r_en         = bus.i_cpu_r_en;
         bus.o_mem_r_addr       = bus.i_cpu_r_addr;
         bus.o_mem_r_signing    = bus.i_cpu_r_signing;
         bus.o_mem_r_addressing = bus.i_cpu_r_addressing;
         bus.o_mem_w_en         = bus.i_cpu_w_en;
         bus.o_mem_w_addr       = bus.i_cpu_w_addr;
         bus.o_mem_w_data       = bus.i_cpu_w_data;
         bus.o_mem_w_addressing = bus.i_cpu_w_addressing;
      end else if (r_state == ST_RD) begin
         bus.o_mem_r_en         = 1'b1;
         bus.o_mem_r_addr       = w_word_addr;
         bus.o_mem_r_addressing = 2'b11;
      end
   end

   assign bus.o_cpu_r_data = bus.i_mem_r_data;
   assign bus.o_cpu_stall  = (r_state != ST_IDLE);
   assign bus.o_dbg_valid  = r_dbg_valid;
   assign bus.o_dbg_data   = r_dbg_data;
   assign bus.o_dbg_addr   = r_dbg_addr;
   assign bus.o_dbg_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressable memory model with 1-cycle read
// latency, table of CPU passthrough vectors, then directed dump sequences.
module tb_dmem_arbiter;
   localparam int NB_DATA_BUS = 32;
   localparam int N_ADDRESS   = 64;
   localparam int NB_ADDRESS  = 6;

   logic clk;
   logic rst;
   logic preload;
   int   n_pass;
   int   n_total;

   dmem_arbiter_if #(.NB_DATA_BUS(NB_DATA_BUS), .NB_ADDRESS(NB_ADDRESS)) bus ();

   dmem_arbiter #(
      .NB_DATA_BUS(NB_DATA_BUS),
      .N_ADDRESS  (N_ADDRESS),
      .NB_ADDRESS (NB_ADDRESS)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [7:0]  mem [0:N_ADDRESS-1];
   logic [31:0] r_mem_rdata;
   assign bus.i_mem_r_data = r_mem_rdata;

   function automatic logic [31:0] mem_read(input logic [5:0] a, input logic [1:0] sz,
                                            input logic sgn);
      logic [7:0] b0, b1, b2, b3;
      b0 = mem[a];
      b1 = mem[6'(a + 6'd1)];
      b2 = mem[6'(a + 6'd2)];
      b3 = mem[6'(a + 6'd3)];
      case (sz)
         2'b11:   return {b3, b2, b1, b0};
         2'b01:   return {{16{sgn & b1[7]}}, b1, b0};
         default: return {{24{sgn & b0[7]}}, b0};
      endcase
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < N_ADDRESS / 4; i++)
            for (int j = 0; j < 4; j++)
               mem[4*i+j] <= 8'((32'h1000 + i) >> (8 * j));
      end else if (bus.o_mem_w_en) begin
         mem[bus.o_mem_w_addr] <= bus.o_mem_w_data[7:0];
         if (bus.o_mem_w_addressing != 2'b00)
            mem[6'(bus.o_mem_w_addr + 6'd1)] <= bus.o_mem_w_data[15:8];
         if (bus.o_mem_w_addressing == 2'b11) begin
            mem[6'(bus.o_mem_w_addr + 6'd2)] <= bus.o_mem_w_data[23:16];
            mem[6'(bus.o_mem_w_addr + 6'd3)] <= bus.o_mem_w_data[31:24];
         end
      end
      if (bus.o_mem_r_en)
         r_mem_rdata <= mem_read(bus.o_mem_r_addr, bus.o_mem_r_addressing, bus.o_mem_r_signing);
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask

   task automatic cpu_idle();
      bus.i_cpu_r_en         = 1'b0;
      bus.i_cpu_r_addr       = '0;
      bus.i_cpu_r_signing    = 1'b0;
      bus.i_cpu_r_addressing = 2'b00;
      bus.i_cpu_w_en         = 1'b0;
      bus.i_cpu_w_addr       = '0;
      bus.i_cpu_w_data       = '0;
      bus.i_cpu_w_addressing = 2'b00;
   endtask

   task automatic do_preload();
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   // Drives one dump and checks it beat by beat. Cycle 0 is the negedge on
   // which halted is raised (and start pulsed unless already pending).
   task automatic run_dump(input int bp_word, input int bp_len, input bit attack,
                           input bit restart, input bit drop_halt, input int abort_at,
                           input bit skip_start);
      int beat, cyc, hold, last_hs;
      bit done_seen, pulsed;
      beat = 0; cyc = 0; hold = 0; last_hs = -10; done_seen = 0; pulsed = 0;
      @(negedge clk);
      chk1("dump_c0_stall", bus.o_cpu_stall, 1'b0);
      bus.i_dbg_halted = 1'b1;
      bus.i_dbg_ready  = 1'b1;
      if (!skip_start) bus.i_dbg_dump_start = 1'b1;
      while (!done_seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
         bus.i_dbg_dump_start = 1'b0;
         if (abort_at >= 0 && beat == abort_at) return;
         chk1("dump_stall", bus.o_cpu_stall, 1'b1);
         chk1("dump_w_en", bus.o_mem_w_en, 1'b0);
         chk("dump_w_data", bus.o_mem_w_data, 32'h0);
         chk("dump_w_addr", 32'(bus.o_mem_w_addr), 32'h0);
         if (cyc == 1) begin
            chk1("first_rd_en", bus.o_mem_r_en, 1'b1);
            chk("first_rd_addr", 32'(bus.o_mem_r_addr), 32'h0);
         end
         if (attack) begin
            bus.i_cpu_w_en         = 1'b1;
            bus.i_cpu_w_addr       = 6'h08;
            bus.i_cpu_w_data       = 32'hDEADBEEF;
            bus.i_cpu_w_addressing = 2'b11;
         end
         if (restart && !pulsed && beat == 5) begin
            bus.i_dbg_dump_start = 1'b1;
            pulsed = 1;
         end
         if (drop_halt && beat >= 8) bus.i_dbg_halted = 1'b0;
         if (bus.o_mem_r_en) begin
            chk("rd_addr", 32'(bus.o_mem_r_addr), 32'(beat * 4));
            chk("rd_size", 32'(bus.o_mem_r_addressing), 32'd3);
            chk1("rd_sign", bus.o_mem_r_signing, 1'b0);
         end
         if (bus.o_dbg_valid) begin
            chk("beat_data", bus.o_dbg_data, 32'h1000 + 32'(beat));
            chk("beat_addr", 32'(bus.o_dbg_addr), 32'(beat * 4));
            if (beat == bp_word && hold < bp_len) begin
               bus.i_dbg_ready = 1'b0;
               hold++;
               chk1("hold_no_rd", bus.o_mem_r_en, 1'b0);
            end else begin
               bus.i_dbg_ready = 1'b1;
               beat++;
               last_hs = cyc;
            end
         end
         if (bus.o_dbg_done) begin
            done_seen = 1;
            chk("done_after_last", 32'(cyc), 32'(last_hs + 1));
            chk("dump_cycles", 32'(cyc + 1), 32'(50 + bp_len));
         end
      end
      if (!done_seen) chk1("dump_timeout", 1'b0, 1'b1);
      chk("dump_beats", 32'(beat), 32'd16);
      cpu_idle();
      @(negedge clk);
      chk1("post_done", bus.o_dbg_done, 1'b0);
      chk1("post_stall", bus.o_cpu_stall, 1'b0);
      chk1("post_valid", bus.o_dbg_valid, 1'b0);
   endtask

   // ---------------- passthrough vector table ----------------
   typedef struct {
      logic        r_en;
      logic [5:0]  r_addr;
      logic        sgn;
      logic [1:0]  r_sz;
      logic        w_en;
      logic [5:0]  w_addr;
      logic [31:0] w_data;
      logic [1:0]  w_sz;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      preload = 1'b0;
      rst = 1'b1;
      cpu_idle();
      bus.i_dbg_halted     = 1'b0;
      bus.i_dbg_dump_start = 1'b0;
      bus.i_dbg_ready      = 1'b1;

      //          r_en addr  sgn sz    w_en addr  data          sz    chk exp
      vecs[0] = '{1'b0, 6'h00, 1'b0, 2'b00, 1'b1, 6'h05, 32'h000000A5, 2'b00, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 6'h04, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'h0000A501};
      vecs[2] = '{1'b1, 6'h05, 1'b1, 2'b00, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'hFFFFFFA5};
      vecs[3] = '{1'b1, 6'h05, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'h000000A5};
      vecs[4] = '{1'b1, 6'h04, 1'b1, 2'b01, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'hFFFFA501};
      vecs[5] = '{1'b1, 6'h00, 1'b0, 2'b11, 1'b1, 6'h0A, 32'h00008001, 2'b01, 1'b1, 32'h00001000};
      vecs[6] = '{1'b1, 6'h08, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'h80011002};
      vecs[7] = '{1'b1, 6'h0A, 1'b0, 2'b01, 1'b1, 6'h0C, 32'h12345678, 2'b11, 1'b1, 32'h00008001};
      vecs[8] = '{1'b1, 6'h0C, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0,        2'b00, 1'b1, 32'h12345678};

      // reset state
      repeat (2) @(negedge clk);
      chk1("rst_valid", bus.o_dbg_valid, 1'b0);
      chk("rst_data", bus.o_dbg_data, 32'h0);
      chk("rst_addr", 32'(bus.o_dbg_addr), 32'h0);
      chk1("rst_done", bus.o_dbg_done, 1'b0);
      chk1("rst_stall", bus.o_cpu_stall, 1'b0);
      rst = 1'b0;
      do_preload();

      // CPU passthrough vectors
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.i_cpu_r_en         = vecs[i].r_en;
         bus.i_cpu_r_addr       = vecs[i].r_addr;
         bus.i_cpu_r_signing    = vecs[i].sgn;
         bus.i_cpu_r_addressing = vecs[i].r_sz;
         bus.i_cpu_w_en         = vecs[i].w_en;
         bus.i_cpu_w_addr       = vecs[i].w_addr;
         bus.i_cpu_w_data       = vecs[i].w_data;
         bus.i_cpu_w_addressing = vecs[i].w_sz;
         #1;
         chk1("pt_r_en", bus.o_mem_r_en, vecs[i].r_en);
         chk("pt_r_addr", 32'(bus.o_mem_r_addr), 32'(vecs[i].r_addr));
         chk1("pt_r_sign", bus.o_mem_r_signing, vecs[i].sgn);
         chk("pt_r_size", 32'(bus.o_mem_r_addressing), 32'(vecs[i].r_sz));
         chk1("pt_w_en", bus.o_mem_w_en, vecs[i].w_en);
         chk("pt_w_addr", 32'(bus.o_mem_w_addr), 32'(vecs[i].w_addr));
         chk("pt_w_data", bus.o_mem_w_data, vecs[i].w_data);
         chk("pt_w_size", 32'(bus.o_mem_w_addressing), 32'(vecs[i].w_sz));
         chk1("pt_stall", bus.o_cpu_stall, 1'b0);
         @(posedge clk);
         #1;
         if (vecs[i].chk_rd) chk("pt_rdata", bus.o_cpu_r_data, vecs[i].exp_rd);
      end
      cpu_idle();
      do_preload();

      // full dump, ready held high
      run_dump(-1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      // backpressure on word 3, with CPU write attempts throughout
      run_dump(3, 5, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      @(negedge clk);
      bus.i_cpu_r_en         = 1'b1;
      bus.i_cpu_r_addr       = 6'h08;
      bus.i_cpu_r_addressing = 2'b11;
      @(posedge clk);
      #1;
      chk("word8_unchanged", bus.o_cpu_r_data, 32'h00001002);
      @(negedge clk);
      cpu_idle();

      // deferred start: request while running, halted rises 10 cycles later
      bus.i_dbg_halted = 1'b0;
      @(negedge clk);
      bus.i_dbg_dump_start = 1'b1;
      @(negedge clk);
      bus.i_dbg_dump_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk1("defer_stall", bus.o_cpu_stall, 1'b0);
         chk1("defer_rd", bus.o_mem_r_en, 1'b0);
      end
      // second start mid-dump ignored; halted drops mid-dump without abort
      run_dump(-1, 0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      bus.i_dbg_halted = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk1("no_second_dump", bus.o_cpu_stall, 1'b0);
         chk1("no_second_valid", bus.o_dbg_valid, 1'b0);
      end

      // reset after word 7, then a fresh dump from address 0
      run_dump(-1, 0, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      rst = 1'b1;
      bus.i_dbg_ready = 1'b1;
      @(posedge clk);
      #1;
      chk1("abort_valid", bus.o_dbg_valid, 1'b0);
      chk1("abort_done", bus.o_dbg_done, 1'b0);
      chk1("abort_stall", bus.o_cpu_stall, 1'b0);
      chk("abort_data", bus.o_dbg_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk1("abort_idle_done", bus.o_dbg_done, 1'b0);
      run_dump(-1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
